// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
// Pure declarations: no latency, no flow control.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  // Load result returned when an access is aborted by timeout.
  localparam int unsigned TIMEOUT_RDATA = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Latency 1 cycle from inc_i to cnt_o; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: IDLE -> BUSY (req held until ack/timeout) -> DONE, min 3 cycles.
// Backpressure: stall freezes the pipeline from the access cycle until the DONE cycle.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvld_q, rvld_d;
  logic              terr_q, terr_d;
  logic              terr_set;
  logic              access;

  assign access = memRead_in | memWrite_in;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvld_d   = 1'b0;
    terr_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          addr_d  = addr_in;
          wdata_d = wdata_in;
          we_d    = memWrite_in;
          timer_d = '0;
          req_d   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // An ack arriving on the final allowed cycle still completes normally.
        if (mem_ack) begin
          if (!we_q) rdata_d = mem_rdata;
          req_d   = 1'b0;
          rvld_d  = 1'b1;
          state_d = ST_DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rdata_d  = DATA_W'(TIMEOUT_RDATA);
          terr_set = 1'b1;
          req_d    = 1'b0;
          rvld_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    terr_d = terr_set ? 1'b1 : (err_clr ? 1'b0 : terr_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      terr_q  <= terr_d;
    end
  end

  assign stall = ((state_q == ST_IDLE) && access) || (state_q == ST_BUSY);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (stall),
    .clr_i (1'b0),
    .cnt_o (stall_cnt)
  );

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign rdata_out   = rdata_q;
  assign rdata_valid = rvld_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: instance a (long timeout, wide counter), instance b (TIMEOUT=4, CNT_W=2).
// Completion responses are checked by a scoreboard monitor; cycle-level outputs by directed checks.
module tb_mem_access_ctrl;

  typedef struct packed {
    logic [31:0] rdata;
    logic        terr;
  } exp_t;

  logic clk, rst;

  logic        a_rd, a_wr, a_ack, a_clr;
  logic [31:0] a_addr, a_wdata, a_mrdata;
  logic        a_req, a_we, a_stall, a_rvld, a_terr;
  logic [31:0] a_maddr, a_mwdata, a_rdata;
  logic [15:0] a_cnt;

  logic        b_rd, b_wr, b_ack, b_clr;
  logic [31:0] b_addr, b_wdata, b_mrdata;
  logic        b_req, b_we, b_stall, b_rvld, b_terr;
  logic [31:0] b_maddr, b_mwdata, b_rdata;
  logic [1:0]  b_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea, eb;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .memRead_in(a_rd), .memWrite_in(a_wr), .addr_in(a_addr),
    .wdata_in(a_wdata), .mem_req(a_req), .mem_we(a_we), .mem_addr(a_maddr),
    .mem_wdata(a_mwdata), .mem_ack(a_ack), .mem_rdata(a_mrdata), .stall(a_stall),
    .rdata_out(a_rdata), .rdata_valid(a_rvld), .timeout_err(a_terr), .err_clr(a_clr),
    .stall_cnt(a_cnt)
  );

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .memRead_in(b_rd), .memWrite_in(b_wr), .addr_in(b_addr),
    .wdata_in(b_wdata), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_maddr),
    .mem_wdata(b_mwdata), .mem_ack(b_ack), .mem_rdata(b_mrdata), .stall(b_stall),
    .rdata_out(b_rdata), .rdata_valid(b_rvld), .timeout_err(b_terr), .err_clr(b_clr),
    .stall_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (a_rvld) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_spurious_valid actual rdata=0x%0h required no completion", a_rdata);
      end else begin
        ea = exp_a.pop_front();
        chk("a_rdata_out", a_rdata, ea.rdata);
        chk("a_timeout_err", {31'b0, a_terr}, {31'b0, ea.terr});
      end
    end
    if (b_rvld) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_spurious_valid actual rdata=0x%0h required no completion", b_rdata);
      end else begin
        eb = exp_b.pop_front();
        chk("b_rdata_out", b_rdata, eb.rdata);
        chk("b_timeout_err", {31'b0, b_terr}, {31'b0, eb.terr});
      end
    end
  end

  initial begin
    rst = 1'b0;
    a_rd = 0; a_wr = 0; a_ack = 0; a_clr = 0; a_addr = 0; a_wdata = 0; a_mrdata = 0;
    b_rd = 0; b_wr = 0; b_ack = 0; b_clr = 0; b_addr = 0; b_wdata = 0; b_mrdata = 0;
    tick; tick; settle;
    chk("rst_a_req", a_req, 0);
    chk("rst_a_stall", a_stall, 0);
    chk("rst_a_rvld", a_rvld, 0);
    chk("rst_a_terr", a_terr, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_a_maddr", a_maddr, 0);
    chk("rst_b_cnt", b_cnt, 0);
    rst = 1'b1;

    // Load on a, ack in first BUSY cycle
    tick; a_rd = 1; a_addr = 32'h40; exp_a.push_back({32'h1234_5678, 1'b0}); settle;
    chk("ld_c0_stall", a_stall, 1);
    chk("ld_c0_req", a_req, 0);
    tick; a_ack = 1; a_mrdata = 32'h1234_5678; settle;
    chk("ld_c1_stall", a_stall, 1);
    chk("ld_c1_req", a_req, 1);
    chk("ld_c1_we", a_we, 0);
    chk("ld_c1_addr", a_maddr, 32'h40);
    tick; a_ack = 0; settle;
    chk("ld_c2_stall", a_stall, 0);
    chk("ld_c2_rvld", a_rvld, 1);
    chk("ld_c2_cnt", a_cnt, 2);
    chk("ld_c2_req", a_req, 0);
    tick; a_rd = 0; settle;
    chk("ld_c3_rvld", a_rvld, 0);

    // Store on a, ack in fifth BUSY cycle; ack data must not reach rdata_out
    tick; a_wr = 1; a_addr = 32'h100; a_wdata = 32'hCAFE; exp_a.push_back({32'h1234_5678, 1'b0}); settle;
    chk("st_c0_stall", a_stall, 1);
    for (int k = 1; k <= 5; k++) begin
      tick; a_ack = (k == 5); a_mrdata = 32'hDEAD_0000 | k; settle;
      chk("st_stall", a_stall, 1);
      chk("st_req", a_req, 1);
      chk("st_we", a_we, 1);
      chk("st_addr", a_maddr, 32'h100);
      chk("st_wdata", a_mwdata, 32'hCAFE);
    end
    tick; a_ack = 0; a_wr = 0; settle;
    chk("st_done_stall", a_stall, 0);
    chk("st_done_rvld", a_rvld, 1);
    chk("st_done_cnt", a_cnt, 8);

    // Ack while idle is ignored
    tick; a_ack = 1; a_mrdata = 32'hFFFF_FFFF; settle;
    chk("idle_ack_stall", a_stall, 0);
    tick; a_ack = 0; settle;
    chk("idle_ack_rvld", a_rvld, 0);
    chk("idle_ack_rdata", a_rdata, 32'h1234_5678);

    // Non-memory instructions: no stall, no request
    for (int k = 0; k < 4; k++) begin
      tick; a_addr = 32'h500 + k; settle;
      chk("nomem_stall", a_stall, 0);
      chk("nomem_req", a_req, 0);
    end
    chk("nomem_cnt", a_cnt, 8);

    // Read and write together behave as a write
    tick; a_rd = 1; a_wr = 1; a_addr = 32'h300; a_wdata = 32'h55; exp_a.push_back({32'h1234_5678, 1'b0}); settle;
    tick; a_ack = 1; a_mrdata = 32'hDEAD_BEEF; settle;
    chk("rw_we", a_we, 1);
    chk("rw_wdata", a_mwdata, 32'h55);
    tick; a_ack = 0; a_rd = 0; a_wr = 0; settle;
    chk("rw_rvld", a_rvld, 1);

    // Back-to-back loads: second request only after DONE
    tick; a_rd = 1; a_addr = 32'h200; exp_a.push_back({32'hAAAA_0001, 1'b0}); settle;
    tick; a_ack = 1; a_mrdata = 32'hAAAA_0001; settle;
    chk("b2b_addr0", a_maddr, 32'h200);
    tick; a_ack = 0; a_addr = 32'h204; settle;
    chk("b2b_done_stall", a_stall, 0);
    chk("b2b_done_req", a_req, 0);
    tick; exp_a.push_back({32'hBBBB_0002, 1'b0}); settle;
    chk("b2b_c3_stall", a_stall, 1);
    chk("b2b_c3_req", a_req, 0);
    tick; a_ack = 1; a_mrdata = 32'hBBBB_0002; settle;
    chk("b2b_c4_req", a_req, 1);
    chk("b2b_addr1", a_maddr, 32'h204);
    tick; a_ack = 0; a_rd = 0; settle;
    chk("b2b_rvld", a_rvld, 1);
    chk("b2b_cnt", a_cnt, 14);

    // b: load with ack in second BUSY cycle; 2-bit stall counter climbs to 3
    tick; b_rd = 1; b_addr = 32'h10; exp_b.push_back({32'h77, 1'b0}); settle;
    chk("b_ld_cnt0", b_cnt, 0);
    tick; settle;
    chk("b_ld_cnt1", b_cnt, 1);
    tick; b_ack = 1; b_mrdata = 32'h77; settle;
    chk("b_ld_cnt2", b_cnt, 2);
    tick; b_ack = 0; b_rd = 0; settle;
    chk("b_ld_cnt3", b_cnt, 3);

    // b: timeout after 4 BUSY cycles
    tick; b_rd = 1; b_addr = 32'h14; exp_b.push_back({32'h0, 1'b1}); settle;
    for (int k = 1; k <= 4; k++) begin
      tick; settle;
      chk("to_req", b_req, 1);
      chk("to_terr_early", b_terr, 0);
    end
    tick; b_rd = 0; settle;
    chk("to_done_req", b_req, 0);
    chk("to_done_stall", b_stall, 0);
    chk("to_done_terr", b_terr, 1);
    chk("to_cnt_sat", b_cnt, 3);
    tick; b_clr = 1; settle;
    chk("clr_pending", b_terr, 1);
    tick; b_clr = 0; settle;
    chk("clr_done", b_terr, 0);

    // b: err_clr held through the setting cycle; set wins
    tick; b_rd = 1; b_clr = 1; exp_b.push_back({32'h0, 1'b1}); settle;
    for (int k = 1; k <= 4; k++) begin
      tick; settle;
    end
    tick; b_rd = 0; b_clr = 0; settle;
    chk("setwin_terr", b_terr, 1);
    tick; settle;
    chk("setwin_sticky", b_terr, 1);
    tick; b_clr = 1; settle;
    tick; b_clr = 0; settle;
    chk("setwin_clr", b_terr, 0);

    // b: ack on the timeout cycle wins
    tick; b_rd = 1; exp_b.push_back({32'h4444, 1'b0}); settle;
    for (int k = 1; k <= 4; k++) begin
      tick; b_ack = (k == 4); b_mrdata = 32'h4444; settle;
      chk("ackwin_req", b_req, 1);
    end
    tick; b_ack = 0; b_rd = 0; settle;
    chk("ackwin_terr", b_terr, 0);
    chk("ackwin_rvld", b_rvld, 1);

    // a: reset asserted mid-access drops everything; late ack ignored
    tick; a_rd = 1; a_addr = 32'h400; settle;
    tick; settle;
    chk("rb_req1", a_req, 1);
    tick; settle;
    chk("rb_req2", a_req, 1);
    #1; rst = 1'b0; a_rd = 0; #1;
    chk("rb_req_drop", a_req, 0);
    chk("rb_stall_drop", a_stall, 0);
    chk("rb_cnt_clr", a_cnt, 0);
    tick; tick; rst = 1'b1;
    tick; a_ack = 1; a_mrdata = 32'h9999; settle;
    chk("rb_late_stall", a_stall, 0);
    tick; a_ack = 0; settle;
    chk("rb_late_rvld", a_rvld, 0);
    chk("rb_late_rdata", a_rdata, 0);
    chk("rb_late_req", a_req, 0);
    tick; settle;

    chk("a_queue_empty", exp_a.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
